// File: rtl/keypad_pkg.sv
// Shared keypad constants, widths, debounce states and key lookup.
package keypad_pkg;

    localparam int unsigned ROW_W  = 4;
    localparam int unsigned COL_W  = 3;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned DIG_W  = 3;
    localparam int unsigned FAIL_W = 2;

    localparam logic [CODE_W-1:0] KEY_STAR = 4'hA;
    localparam logic [CODE_W-1:0] KEY_HASH = 4'hB;

    typedef enum logic [1:0] {
        DEB_IDLE  = 2'd0,
        DEB_PRESS = 2'd1,
        DEB_HELD  = 2'd2
    } deb_state_e;

    // Map a one-hot row/column pair to its key code; rows 0..2 hold digits 1..9.
    function automatic logic [CODE_W-1:0] key_lookup(input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] col);
        logic [1:0]        r;
        logic [1:0]        c;
        logic [CODE_W-1:0] code;
        r = row[3] ? 2'd3 : row[2] ? 2'd2 : row[1] ? 2'd1 : 2'd0;
        c = col[2] ? 2'd2 : col[1] ? 2'd1 : 2'd0;
        if (r == 2'd3) begin
            case (c)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = CODE_W'(3 * r + c + 1);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_pin_entry_if.sv
// Keypad lines in, key/verdict/lockout status out.
interface keypad_pin_entry_if;
    import keypad_pkg::*;

    logic [ROW_W-1:0]  fila;
    logic [COL_W-1:0]  Columna;
    logic              enter;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic [DIG_W-1:0]  digits;
    logic              code_ok;
    logic              code_bad;
    logic              locked;
    logic [FAIL_W-1:0] fail_cnt;

    modport master (
        output fila, Columna, enter,
        input  key_valid, key_code, digits, code_ok, code_bad, locked, fail_cnt
    );

    modport slave (
        input  fila, Columna, enter,
        output key_valid, key_code, digits, code_ok, code_bad, locked, fail_cnt
    );

endinterface

// File: rtl/keypad_debouncer.sv
// Synchronizes the matrix lines, decodes one-hot presses and debounces press and release.
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code
);

    localparam int unsigned PAT_W = ROW_W + COL_W;
    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic [PAT_W-1:0] pat_s1;
    logic [PAT_W-1:0] pat_s2;
    logic [PAT_W-1:0] pat_lat;
    logic [CNT_W-1:0] cnt;
    deb_state_e       state;
    logic             pat_valid;

    assign pat_valid = $onehot(pat_s2[PAT_W-1:COL_W]) && $onehot(pat_s2[COL_W-1:0]);

    // The IDLE cycle that sees the pattern counts as the first stable cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_s1    <= '0;
            pat_s2    <= '0;
            pat_lat   <= '0;
            cnt       <= '0;
            state     <= DEB_IDLE;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            pat_s1    <= {row, col};
            pat_s2    <= pat_s1;
            key_valid <= 1'b0;
            case (state)
                DEB_IDLE: begin
                    if (pat_valid) begin
                        pat_lat <= pat_s2;
                        cnt     <= '0;
                        state   <= DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (pat_s2 != pat_lat) begin
                        state <= DEB_IDLE;
                    end else if (cnt == CNT_W'(DEB_CYCLES - 2)) begin
                        key_valid <= 1'b1;
                        key_code  <= key_lookup(pat_lat[PAT_W-1:COL_W], pat_lat[COL_W-1:0]);
                        cnt       <= '0;
                        state     <= DEB_HELD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DEB_HELD: begin
                    if (pat_s2 != '0) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= DEB_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= DEB_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/keypad_pin_entry.sv
// PIN entry front end: digit buffer, enter/# judging, fail counting and timed lockout.
module keypad_pin_entry
    import keypad_pkg::*;
#(
    parameter int unsigned          DEB_CYCLES  = 500000,
    parameter int unsigned          CODE_LEN    = 4,
    parameter logic [4*CODE_LEN-1:0] SECRET     = 16'h1234,
    parameter int unsigned          MAX_FAIL    = 3,
    parameter int unsigned          LOCK_CYCLES = 1000000000
) (
    input logic               clk,
    input logic               rst2,
    keypad_pin_entry_if.slave bus
);

    localparam int unsigned BUF_W  = CODE_W * CODE_LEN;
    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

    logic              kv;
    logic [CODE_W-1:0] kc;
    logic [1:0]        ent_sync;
    logic              ent_prev;
    logic [BUF_W-1:0]  pin_buf;
    logic [DIG_W-1:0]  digits;
    logic              code_ok;
    logic              code_bad;
    logic              locked;
    logic [FAIL_W-1:0] fail_cnt;
    logic [LOCK_W-1:0] lock_cnt;
    logic              ent_rise;
    logic              enter_evt;
    logic              digit_evt;
    logic              star_evt;
    logic              code_match;

    keypad_debouncer #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk      (clk),
        .rst_n    (rst2),
        .row      (bus.fila),
        .col      (bus.Columna),
        .key_valid(kv),
        .key_code (kc)
    );

    // An enter edge in the same cycle as a key accept swallows the key.
    assign ent_rise   = ent_sync[1] & ~ent_prev;
    assign enter_evt  = ent_rise | (kv & (kc == KEY_HASH));
    assign digit_evt  = kv & ~ent_rise & (kc <= CODE_W'(9)) & (digits < DIG_W'(CODE_LEN));
    assign star_evt   = kv & ~ent_rise & (kc == KEY_STAR);
    assign code_match = (digits == DIG_W'(CODE_LEN)) && (pin_buf == SECRET);

    // Lockout, and the cycle that arms it, freeze buffer, verdicts and fail count.
    always_ff @(posedge clk or negedge rst2) begin
        if (!rst2) begin
            ent_sync <= '0;
            ent_prev <= 1'b0;
            pin_buf  <= '0;
            digits   <= '0;
            code_ok  <= 1'b0;
            code_bad <= 1'b0;
            locked   <= 1'b0;
            fail_cnt <= '0;
            lock_cnt <= '0;
        end else begin
            ent_sync <= {ent_sync[0], bus.enter};
            ent_prev <= ent_sync[1];
            code_ok  <= 1'b0;
            code_bad <= 1'b0;
            if (locked) begin
                if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
                    locked   <= 1'b0;
                    lock_cnt <= '0;
                    fail_cnt <= '0;
                end else begin
                    lock_cnt <= lock_cnt + 1'b1;
                end
            end else if (fail_cnt == FAIL_W'(MAX_FAIL)) begin
                locked   <= 1'b1;
                lock_cnt <= '0;
            end else if (enter_evt) begin
                if (code_match) begin
                    code_ok  <= 1'b1;
                    fail_cnt <= '0;
                end else begin
                    code_bad <= 1'b1;
                    fail_cnt <= fail_cnt + 1'b1;
                end
                pin_buf <= '0;
                digits  <= '0;
            end else if (digit_evt) begin
                pin_buf <= {pin_buf[BUF_W-CODE_W-1:0], kc};
                digits  <= digits + 1'b1;
            end else if (star_evt) begin
                pin_buf <= '0;
                digits  <= '0;
            end
        end
    end

    assign bus.key_valid = kv;
    assign bus.key_code  = kc;
    assign bus.digits    = digits;
    assign bus.code_ok   = code_ok;
    assign bus.code_bad  = code_bad;
    assign bus.locked    = locked;
    assign bus.fail_cnt  = fail_cnt;

endmodule
